// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The optional macro FIFO_ARB_PRIO_EN is interpreted in fifo_wr_arbiter.sv.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above start_i,
// wrapping modulo NUM_REQ (works for non-power-of-2 NUM_REQ).
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic               found_o,
  output logic [ID_W-1:0]    winner_o
);

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    int idx;
    idx      = 0;
    found_o  = 1'b0;
    winner_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx      = (int'(start_i) + k) % NUM_REQ;
      found_o  = found_o | req_i[idx];
      winner_o = req_i[idx] ? ID_W'(idx) : winner_o;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the shared FIFO write port.
// Define FIFO_ARB_PRIO_EN to give requester 0 fixed priority in IDLE.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic                        fifo_en,
  output logic [DATA_W-1:0]           fifo_data,
  output logic                        grant_valid,
  output logic [id_width(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = beat_cnt_width(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_id_s;
  logic [ID_W-1:0]  win_id_s;
  logic             ptr_hold_s;
  logic             in_burst_s;
  logic             accept_s;
  logic             burst_end_s;
  logic [ID_W-1:0]  next_ptr_s;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i    (req_valid),
    .start_i  (rr_ptr_q),
    .found_o  (pick_found_s),
    .winner_o (pick_id_s)
  );

`ifdef FIFO_ARB_PRIO_EN
  // Requester 0 pre-empts the rotation only when choosing a new owner.
  assign win_id_s   = req_valid[0] ? '0 : pick_id_s;
  assign ptr_hold_s = (owner_q == '0);
`else
  assign win_id_s   = pick_id_s;
  assign ptr_hold_s = 1'b0;
`endif

  assign in_burst_s  = (state_q == ARB_BURST);
  assign accept_s    = in_burst_s & req_valid[owner_q] & ~fifo_full;
  assign burst_end_s = req_last[owner_q] | (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign next_ptr_s  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  // Next-state logic for arbitration FSM, owner, pointer and beat counter.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d    = ARB_BURST;
          owner_d    = win_id_s;
          beat_cnt_d = '0;
        end else begin
          state_d    = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (accept_s && burst_end_s) begin
          state_d    = ARB_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = ptr_hold_s ? rr_ptr_q : next_ptr_s;
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (in_burst_s) begin
      req_ready[owner_q] = ~fifo_full;
    end else begin
      req_ready = '0;
    end
  end

  assign fifo_wr     = accept_s;
  assign fifo_data   = in_burst_s ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
  assign fifo_en     = ~Rst;
  assign grant_valid = in_burst_s;
  assign grant_id    = in_burst_s ? owner_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural
// model built from per-requester beat queues and a round-robin search.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;
`ifdef FIFO_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                      Clk = 1'b0;
  logic                      Rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full = 1'b0;
  logic                      fifo_wr, fifo_en, grant_valid;
  logic [DATA_W-1:0]         fifo_data;
  logic [ID_W-1:0]           grant_id;

  always #5 Clk = ~Clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_en(fifo_en),
    .fifo_data(fifo_data), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int checks = 0;
  int failures = 0;

  // Pending beats per requester: bit DATA_W is the last flag.
  logic [DATA_W:0]   bq [NUM_REQ][$];
  bit   [NUM_REQ-1:0] hold;
  logic [ID_W-1:0]   glog [$];
  logic [DATA_W-1:0] wlog [$];
  bit   prev_gv;
  int   p_valid, p_full;
  bit   force_full;
  int   seq_no = 0;

  // Behavioural reference: idle/busy, current owner, beats sent, rotation pointer.
  bit m_busy;
  int m_owner, m_beats, m_ptr;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gl(input int k);
    return (k < glog.size()) ? 64'(glog[k]) : '1;
  endfunction

  function automatic logic [63:0] wl(input int k);
    return (k < wlog.size()) ? 64'(wlog[k]) : '1;
  endfunction

  task automatic push_beat(input int i, input logic [DATA_W-1:0] d, input bit last);
    bq[i].push_back({last, d});
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #1;
    chk_eq("rst_ready", req_ready, 0);
    chk_eq("rst_wr", fifo_wr, 0);
    chk_eq("rst_gv", grant_valid, 0);
    chk_eq("rst_gid", grant_id, 0);
    chk_eq("rst_data", fifo_data, 0);
    chk_eq("rst_en", fifo_en, 0);
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bq[i].delete();
    hold = '0; glog.delete(); wlog.delete(); prev_gv = 1'b0; force_full = 1'b0;
    p_valid = 100; p_full = 0;
    m_busy = 1'b0; m_owner = 0; m_beats = 0; m_ptr = 0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step();
    logic [DATA_W:0]    head;
    logic [NUM_REQ-1:0] exp_ready;
    bit acc, last;
    int w, idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bq[i].size() == 0) begin
        hold[i] = 1'b0;
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end else begin
        if (!hold[i]) hold[i] = ($urandom_range(99) < p_valid);
        head = bq[i][0];
        req_valid[i] = hold[i];
        req_last[i] = head[DATA_W];
        req_data[i*DATA_W +: DATA_W] = head[DATA_W-1:0];
      end
    end
    fifo_full = force_full | ($urandom_range(99) < p_full);
    #1;
    exp_ready = '0;
    if (m_busy && !fifo_full) exp_ready[m_owner] = 1'b1;
    acc = m_busy && req_valid[m_owner] && !fifo_full;
    chk_eq("req_ready", req_ready, exp_ready);
    chk_eq("fifo_wr", fifo_wr, acc);
    chk_eq("grant_valid", grant_valid, m_busy);
    chk_eq("fifo_en", fifo_en, 1);
    if (m_busy) chk_eq("grant_id", grant_id, m_owner);
    if (acc) begin
      head = bq[m_owner][0];
      chk_eq("fifo_data", fifo_data, head[DATA_W-1:0]);
    end
    if (grant_valid && !prev_gv) glog.push_back(grant_id);
    prev_gv = grant_valid;
    if (fifo_wr) wlog.push_back(fifo_data);
    if (!m_busy) begin
      w = -1;
      if (PRIO && req_valid[0]) w = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_beats = 0;
      end
    end else if (acc) begin
      head = bq[m_owner].pop_front();
      last = head[DATA_W];
      hold[m_owner] = 1'b0;
      m_beats++;
      if (last || m_beats == MAX_BURST) begin
        m_busy = 1'b0;
        if (!(PRIO && m_owner == 0)) m_ptr = (m_owner + 1) % NUM_REQ;
      end
    end
    @(negedge Clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    // Single requester: three beats from requester 2, then rotation resumes at 3.
    do_reset();
    push_beat(2, 32'hA0, 1'b0); push_beat(2, 32'hA1, 1'b0); push_beat(2, 32'hA2, 1'b1);
    run(6);
    chk_eq("single_gid", gl(0), 64'd2);
    chk_eq("single_w0", wl(0), 64'hA0);
    chk_eq("single_w1", wl(1), 64'hA1);
    chk_eq("single_w2", wl(2), 64'hA2);
    chk_eq("single_nw", wlog.size(), 64'd3);
    chk_eq("single_idle", grant_valid, 1'b0);
    push_beat(0, 32'hB0, 1'b1); push_beat(3, 32'hB3, 1'b1);
    run(6);
    chk_eq("ptr3_first", gl(1), 64'd3);
    chk_eq("ptr3_second", gl(2), 64'd0);

    // Fairness: all four valid with single-beat bursts.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_beat(i, 32'hE000 + 32'(r*16 + i), 1'b1);
    run(16);
    for (int k = 0; k < 6; k++) chk_eq("fair_order", gl(k), 64'(k % NUM_REQ));
    chk_eq("fair_rate", wlog.size(), 64'd8);

    // Burst cap: six unmarked beats from requester 1, requester 2 waiting.
    do_reset();
    for (int b = 0; b < 6; b++) push_beat(1, 32'hC10 + 32'(b), 1'b0);
    push_beat(2, 32'hC20, 1'b1);
    run(20);
    chk_eq("cap_g0", gl(0), 64'd1);
    chk_eq("cap_g1", gl(1), 64'd2);
    chk_eq("cap_g2", gl(2), 64'd1);
    for (int b = 0; b < 4; b++) chk_eq("cap_wr", wl(b), 64'hC10 + 64'(b));
    chk_eq("cap_other", wl(4), 64'hC20);
    chk_eq("cap_rest4", wl(5), 64'hC14);
    chk_eq("cap_rest5", wl(6), 64'hC15);

    // FULL stall for five cycles after two beats.
    do_reset();
    for (int b = 0; b < 6; b++) push_beat(0, 32'hD0 + 32'(b), 1'b0);
    for (int c = 0; c < 20 && wlog.size() < 2; c++) step();
    force_full = 1'b1;
    run(5);
    chk_eq("full_nowr", wlog.size(), 64'd2);
    force_full = 1'b0;
    run(20);
    chk_eq("full_count", wlog.size(), 64'd6);
    for (int b = 0; b < 6; b++) chk_eq("full_data", wl(b), 64'hD0 + 64'(b));

    // Reset mid-burst, then arbitration restarts from pointer 0.
    do_reset();
    push_beat(2, 32'hF2, 1'b1);
    run(4);
    for (int b = 0; b < 4; b++) push_beat(1, 32'hF10 + 32'(b), 1'b0);
    for (int c = 0; c < 20 && wlog.size() < 2; c++) step();
    #2;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) push_beat(i, 32'hF00 + 32'(i), 1'b1);
    run(10);
    chk_eq("rst_restart0", gl(0), 64'd0);
    chk_eq("rst_restart1", gl(1), 64'd1);

    // Priority: pointer at 2 with requesters 0 and 3 valid.
    do_reset();
    push_beat(1, 32'h11, 1'b1);
    run(3);
    push_beat(0, 32'h100, 1'b1); push_beat(3, 32'h103, 1'b1);
    run(6);
    chk_eq("prio_first", gl(1), PRIO ? 64'd0 : 64'd3);
    chk_eq("prio_second", gl(2), PRIO ? 64'd3 : 64'd0);

    // Random traffic with random stalls and valid gaps.
    do_reset();
    p_valid = 70; p_full = 20;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bq[i].size() == 0 && $urandom_range(99) < 30) begin
          int len;
          bit with_last;
          len = $urandom_range(1, 6);
          with_last = ($urandom_range(3) != 0);
          for (int b = 0; b < len; b++) begin
            seq_no++;
            push_beat(i, (32'(i) << 24) | 32'(seq_no), with_last && (b == len - 1));
          end
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
